// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: FSM encoding, next-PC selects, instruction width.
package fetch_unit_pkg;

    localparam int unsigned INSTR_BITS  = 32;
    localparam int unsigned STATUS_BITS = 5;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    localparam logic [1:0] PCSEL_INC  = 2'b00;
    localparam logic [1:0] PCSEL_K    = 2'b01;
    localparam logic [1:0] PCSEL_REG  = 2'b10;
    localparam logic [1:0] PCSEL_HOLD = 2'b11;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC mux: PC+4, PC+(K<<2), word-aligned register target, or hold.
module next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_BITS = 64,
    parameter int unsigned K_BITS  = 64
) (
    input  logic [PC_BITS-1:0] pc,
    input  logic [1:0]         pc_sel,
    input  logic [K_BITS-1:0]  k,
    input  logic [PC_BITS-1:0] reg_target,
    output logic [PC_BITS-1:0] pc_plus4_c,
    output logic [PC_BITS-1:0] next_pc_c
);

    logic [PC_BITS-1:0] k_off;
    logic [1:0]         unused_rt_lo;

    // Word offset scaled to bytes, then fitted to the PC width.
    if (K_BITS + 2 > PC_BITS) begin : g_k_trunc
        logic [K_BITS+1:0] k_sh;
        logic              unused_k_hi;
        assign k_sh        = {k, 2'b00};
        assign k_off       = k_sh[PC_BITS-1:0];
        assign unused_k_hi = ^k_sh[K_BITS+1:PC_BITS];
    end else if (K_BITS + 2 == PC_BITS) begin : g_k_exact
        assign k_off = {k, 2'b00};
    end else begin : g_k_sext
        assign k_off = {{(PC_BITS-K_BITS-2){k[K_BITS-1]}}, k, 2'b00};
    end

    assign unused_rt_lo = reg_target[1:0];
    assign pc_plus4_c   = pc + PC_BITS'(4);

    always_comb begin
        next_pc_c = pc;
        unique case (pc_sel)
            PCSEL_INC:  next_pc_c = pc_plus4_c;
            PCSEL_K:    next_pc_c = pc + k_off;
            PCSEL_REG:  next_pc_c = {reg_target[PC_BITS-1:2], 2'b00};
            PCSEL_HOLD: next_pc_c = pc;
            default:    next_pc_c = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, status flags, imem handshake.
// Optional macro FETCH_STATUS_REG_EN registers the status flags; otherwise they pass through.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_BITS = 64,
    parameter int unsigned K_BITS  = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_BITS-1:0]     imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_BITS-1:0]  imem_rdata,
    output logic [INSTR_BITS-1:0]  instruction,
    output logic                   instr_valid,
    input  logic                   advance,
    input  logic [1:0]             pc_sel,
    input  logic [K_BITS-1:0]      K,
    input  logic [PC_BITS-1:0]     reg_target,
    output logic [PC_BITS-1:0]     pc,
    output logic [PC_BITS-1:0]     pc_plus4,
    input  logic                   status_load,
    input  logic [STATUS_BITS-1:0] status_in,
    output logic [STATUS_BITS-1:0] status
);

    logic [0:0]            state_q, state_d;
    logic [PC_BITS-1:0]    pc_q, pc_d;
    logic [INSTR_BITS-1:0] ir_q, ir_d;
    logic [PC_BITS-1:0]    next_pc_c;

    next_pc_calc #(
        .PC_BITS (PC_BITS),
        .K_BITS  (K_BITS)
    ) u_next_pc_calc (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .k          (K),
        .reg_target (reg_target),
        .pc_plus4_c (pc_plus4),
        .next_pc_c  (next_pc_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // FETCH waits for ack and captures IR; EXEC waits for advance and steps the PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (advance) begin
                    pc_d    = next_pc_c;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = ir_q;

`ifdef FETCH_STATUS_REG_EN
    logic [STATUS_BITS-1:0] status_q, status_d;

    always_comb begin
        status_d = status_q;
        if (status_load) begin
            status_d = status_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;
`else
    logic unused_status_load;
    assign unused_status_load = status_load;
    assign status             = status_in;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

    localparam int unsigned PC_BITS = 64;
    localparam int unsigned K_BITS  = 64;

    logic               clock;
    logic               reset;
    logic               imem_req;
    logic [PC_BITS-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic [31:0]        instruction;
    logic               instr_valid;
    logic               advance;
    logic [1:0]         pc_sel;
    logic [K_BITS-1:0]  k_in;
    logic [PC_BITS-1:0] reg_target;
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] pc_plus4;
    logic               status_load;
    logic [4:0]         status_in;
    logic [4:0]         status;

    int n_tests;
    int n_fail;

    fetch_unit #(
        .PC_BITS (PC_BITS),
        .K_BITS  (K_BITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .advance     (advance),
        .pc_sel      (pc_sel),
        .K           (k_in),
        .reg_target  (reg_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .status_load (status_load),
        .status_in   (status_in),
        .status      (status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Starting in FETCH: take a zero-wait fetch, then advance with the given select.
    task automatic fetch_and_advance(input logic [1:0] sel, input logic [63:0] kv,
                                     input logic [63:0] rt);
        imem_ack = 1'b1;
        step();
        imem_ack   = 1'b0;
        advance    = 1'b1;
        pc_sel     = sel;
        k_in       = kv;
        reg_target = rt;
        step();
        advance = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        advance     = 1'b0;
        pc_sel      = 2'b00;
        k_in        = '0;
        reg_target  = '0;
        status_load = 1'b0;
        status_in   = 5'h00;
        step();
        step();
        check("rst_pc", pc, 64'h0);
        check("rst_ir", 64'(instruction), 64'h0);
        check("rst_valid", 64'(instr_valid), 64'h0);
        check("rst_status", 64'(status), 64'h0);

        // First fetch at address 0 with ack held high.
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h8B02_0020;
        #1;
        check("f0_req", 64'(imem_req), 64'h1);
        check("f0_addr", imem_addr, 64'h0);
        check("f0_plus4", pc_plus4, 64'h4);
        step();
        check("f0_ir", 64'(instruction), 64'h8B02_0020);
        check("f0_valid", 64'(instr_valid), 64'h1);
        check("f0_req_exec", 64'(imem_req), 64'h0);

        // Jump to 0x100 via register target, then sequential step.
        imem_ack   = 1'b0;
        advance    = 1'b1;
        pc_sel     = 2'b10;
        reg_target = 64'h100;
        step();
        advance = 1'b0;
        check("reg_100", pc, 64'h100);
        fetch_and_advance(2'b00, 64'h0, 64'h0);
        check("inc_pc", pc, 64'h104);
        check("inc_valid", 64'(instr_valid), 64'h0);
        check("inc_addr", imem_addr, 64'h104);

        fetch_and_advance(2'b10, 64'h0, 64'h2003);
        check("reg_align", pc, 64'h2000);

        fetch_and_advance(2'b10, 64'h0, 64'h100);
        fetch_and_advance(2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
        check("k_neg", pc, 64'hF8);

        fetch_and_advance(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("reg_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("plus4_wrap", pc_plus4, 64'h0);
        fetch_and_advance(2'b01, 64'h1, 64'h0);
        check("k_wrap", pc, 64'h0);

        fetch_and_advance(2'b00, 64'h0, 64'h0);
        fetch_and_advance(2'b11, 64'h0, 64'h0);
        check("hold_pc", pc, 64'h4);
        check("hold_req", 64'(imem_req), 64'h1);

        // Delayed ack: advance pulses in FETCH must not move the PC.
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            advance = 1'b1;
            pc_sel  = 2'b00;
            step();
            check("wait_req", 64'(imem_req), 64'h1);
            check("wait_valid", 64'(instr_valid), 64'h0);
            check("wait_pc", pc, 64'h4);
            check("wait_ir", 64'(instruction), 64'h8B02_0020);
        end
        advance  = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("late_ir", 64'(instruction), 64'hDEAD_BEEF);
        check("late_valid", 64'(instr_valid), 64'h1);

        // Ack ignored in EXEC: IR held.
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        check("exec_ir_hold", 64'(instruction), 64'hDEAD_BEEF);

`ifdef FETCH_STATUS_REG_EN
        status_in   = 5'h0A;
        status_load = 1'b1;
        #1;
        check("st_old", 64'(status), 64'h0);
        step();
        status_load = 1'b0;
        status_in   = 5'h11;
        check("st_load", 64'(status), 64'h0A);
        step();
        check("st_hold", 64'(status), 64'h0A);
`else
        status_in = 5'h0A;
        #1;
        check("st_pass_a", 64'(status), 64'h0A);
        status_in = 5'h15;
        #1;
        check("st_pass_b", 64'(status), 64'h15);
`endif

        // Reset colliding with ack and status_load, while in FETCH at a nonzero PC.
        advance = 1'b1;
        pc_sel  = 2'b00;
        step();
        advance = 1'b0;
        check("pre_rst_pc", pc, 64'h8);
        reset       = 1'b1;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        status_load = 1'b1;
        status_in   = 5'h1F;
        step();
        reset       = 1'b0;
        imem_ack    = 1'b0;
        status_load = 1'b0;
        check("col_pc", pc, 64'h0);
        check("col_ir", 64'(instruction), 64'h0);
        check("col_valid", 64'(instr_valid), 64'h0);
        check("col_req", 64'(imem_req), 64'h1);
`ifdef FETCH_STATUS_REG_EN
        check("col_status", 64'(status), 64'h0);
`else
        check("col_status", 64'(status), 64'h1F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
